shift_reg_universal: RTL and testbench

- Parametrised universal shift register, the general-purpose successor to the fixed 4-bit right shifter.
- Supports hold, right/left shift, right/left rotate, parallel load and clear, selected per cycle.
- Adds a burst engine that applies one latched shift/rotate op N times and flags completion.
- Used as a serializer/deserializer and pattern generator in lab designs; all logic is in the clk domain.

---
 rtl/shift_pkg.sv | 53 +++++
 rtl/shift_reg_universal.sv | 97 +++++++++
 tb/tb_shift_reg_universal.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: op codes, FSM states
// and the reusable op-mux function.
package shift_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned MAX_W = 64;

    localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b001;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b010;
    localparam logic [OP_W-1:0] OP_ROR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ROL  = 3'b100;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b101;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Shift/rotate ops are the only ones a burst can repeat.
    function automatic logic is_burst_op(input logic [OP_W-1:0] op);
        return (op >= OP_SHR) && (op <= OP_ROL);
    endfunction

    // Next register value for a w-bit register held zero-extended in MAX_W bits.
    function automatic logic [MAX_W-1:0] apply_op(
        input logic [OP_W-1:0]  op,
        input logic [MAX_W-1:0] q,
        input logic [MAX_W-1:0] pload,
        input int unsigned      w,
        input logic             sin_r,
        input logic             sin_l
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] msb;
        logic [MAX_W-1:0] r;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        msb  = (q >> (w - 1)) & MAX_W'(1);
        r    = q;
        case (op)
            OP_SHR:  r = (q >> 1) | (MAX_W'(sin_r) << (w - 1));
            OP_SHL:  r = ((q << 1) | MAX_W'(sin_l)) & mask;
            OP_ROR:  r = (q >> 1) | (MAX_W'(q[0]) << (w - 1));
            OP_ROL:  r = ((q << 1) | msb) & mask;
            OP_LOAD: r = pload & mask;
            OP_CLR:  r = '0;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_reg_universal.sv
// Universal shift register with per-cycle op select and a burst engine that
// repeats one latched shift/rotate op nbits times. WIDTH must not exceed 64.
module shift_reg_universal #(
    parameter int unsigned WIDTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pload,
    input  logic             start,
    input  logic [CNT_W-1:0] nbits,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);
    import shift_pkg::*;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [OP_W-1:0]  op_lat, op_lat_n;
    logic [WIDTH-1:0] q_n;
    logic             busy_n, done_n;
    logic [OP_W-1:0]  op_sel;
    logic [WIDTH-1:0] q_op;

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    // Datapath: the burst op takes over from mode while running.
    assign op_sel = (state == S_RUN) ? op_lat : mode;
    assign q_op   = WIDTH'(apply_op(op_sel, MAX_W'(q), MAX_W'(pload), WIDTH, sin_r, sin_l));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_lat <= OP_HOLD;
            q      <= RESET_VAL;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            op_lat <= op_lat_n;
            q      <= q_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next-state and output logic; en low freezes everything including done.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        op_lat_n = op_lat;
        q_n      = q;
        busy_n   = busy;
        done_n   = done;
        if (en) begin
            done_n = 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && is_burst_op(mode)) begin
                        if (nbits != '0) begin
                            op_lat_n = mode;
                            cnt_n    = nbits;
                            state_n  = S_RUN;
                            busy_n   = 1'b1;
                        end else begin
                            done_n = 1'b1;
                        end
                    end else begin
                        q_n = q_op;
                    end
                end
                S_RUN: begin
                    q_n   = q_op;
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed self-checking bench for shift_reg_universal (WIDTH=4, RESET_VAL=1000).
module tb_shift_reg_universal;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  pload;
    logic          start;
    logic [CW-1:0] nbits;
    logic [W-1:0]  q;
    logic          sout_r;
    logic          sout_l;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    shift_reg_universal #(
        .WIDTH    (W),
        .RESET_VAL(4'b1000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .pload (pload),
        .start (start),
        .nbits (nbits),
        .q     (q),
        .sout_r(sout_r),
        .sout_l(sout_l),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [W-1:0] qe, input logic be, input logic de);
        check({tag, ".q"}, 32'(q), 32'(qe));
        check({tag, ".busy"}, 32'(busy), 32'(be));
        check({tag, ".done"}, 32'(done), 32'(de));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0;
        pload = '0; start = 1'b0; nbits = '0;
        tick();
        check_st("reset", 4'b1000, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b1;

        // Direct SHR with sin_r=0
        mode = 3'b001;
        tick(); check("shr1", 32'(q), 32'(4'b0100));
        tick(); check("shr2", 32'(q), 32'(4'b0010));
        tick(); check("shr3", 32'(q), 32'(4'b0001));
        check("sout_r", 32'(sout_r), 32'd1);
        check("sout_l", 32'(sout_l), 32'd0);

        // LOAD then four ROLs restore the value
        mode = 3'b101; pload = 4'b1011;
        tick(); check("load", 32'(q), 32'(4'b1011));
        mode = 3'b100;
        tick(); check("rol1", 32'(q), 32'(4'b0111));
        tick(); check("rol2", 32'(q), 32'(4'b1110));
        tick(); check("rol3", 32'(q), 32'(4'b1101));
        tick(); check("rol4", 32'(q), 32'(4'b1011));
        check("sout_l1", 32'(sout_l), 32'd1);

        // Direct SHL, ROR, reserved hold, en=0 hold, clear
        mode = 3'b010; sin_l = 1'b0;
        tick(); check("shl", 32'(q), 32'(4'b0110));
        mode = 3'b011;
        tick(); check("ror", 32'(q), 32'(4'b0011));
        mode = 3'b111;
        tick(); check("rsvd_hold", 32'(q), 32'(4'b0011));
        mode = 3'b001; en = 1'b0;
        tick(); check("en0_hold", 32'(q), 32'(4'b0011));
        en = 1'b1; mode = 3'b110;
        tick(); check("clear", 32'(q), 32'(4'b0000));

        // Burst SHL nbits=3 sin_l=1; mode toggles during run are ignored
        mode = 3'b010; nbits = 3'd3; sin_l = 1'b1; start = 1'b1;
        tick(); check_st("bshl0", 4'b0000, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b110; pload = 4'b1111;
        tick(); check_st("bshl1", 4'b0001, 1'b1, 1'b0);
        mode = 3'b101;
        tick(); check_st("bshl2", 4'b0011, 1'b1, 1'b0);
        tick(); check_st("bshl3", 4'b0111, 1'b0, 1'b1);
        mode = 3'b000;
        tick(); check_st("bshl4", 4'b0111, 1'b0, 1'b0);

        // Burst ROR nbits=2 with en low two cycles mid-burst
        mode = 3'b101; pload = 4'b0001;
        tick(); check("load1", 32'(q), 32'(4'b0001));
        mode = 3'b011; nbits = 3'd2; start = 1'b1;
        tick(); check_st("bror0", 4'b0001, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick(); check_st("bror1", 4'b1000, 1'b1, 1'b0);
        en = 1'b0;
        tick(); check_st("bror_f1", 4'b1000, 1'b1, 1'b0);
        tick(); check_st("bror_f2", 4'b1000, 1'b1, 1'b0);
        en = 1'b1;
        tick(); check_st("bror2", 4'b0100, 1'b0, 1'b1);
        // done held while en is low
        en = 1'b0;
        tick(); check_st("done_hold", 4'b0100, 1'b0, 1'b1);
        en = 1'b1;
        tick(); check_st("bror3", 4'b0100, 1'b0, 1'b0);

        // nbits=0: no run, single done pulse
        mode = 3'b001; nbits = 3'd0; start = 1'b1;
        tick(); check_st("n0_a", 4'b0100, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick(); check_st("n0_b", 4'b0100, 1'b0, 1'b0);

        // start with a non-shift mode is ignored; mode applies directly
        mode = 3'b101; pload = 4'b0110; nbits = 3'd2; start = 1'b1;
        tick(); check_st("start_load", 4'b0110, 1'b0, 1'b0);
        start = 1'b0; mode = 3'b000;

        // Burst SHR nbits=5 > WIDTH fills with sin_r
        mode = 3'b001; sin_r = 1'b1; nbits = 3'd5; start = 1'b1;
        tick(); check_st("bshr0", 4'b0110, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick(); check_st("bshr1", 4'b1011, 1'b1, 1'b0);
        tick(); tick(); tick();
        check_st("bshr4", 4'b1111, 1'b1, 1'b0);
        tick(); check_st("bshr5", 4'b1111, 1'b0, 1'b1);

        // Burst ROL nbits=4 returns original
        mode = 3'b101; pload = 4'b0110;
        tick();
        mode = 3'b100; nbits = 3'd4; start = 1'b1;
        tick(); start = 1'b0; mode = 3'b000;
        tick(); check_st("brol1", 4'b1100, 1'b1, 1'b0);
        tick(); tick(); tick();
        check_st("brol4", 4'b0110, 1'b0, 1'b1);

        // Reset during a burst aborts it without done
        mode = 3'b010; sin_l = 1'b1; nbits = 3'd3; start = 1'b1;
        tick(); start = 1'b0; mode = 3'b000;
        tick(); check_st("abort_pre", 4'b1101, 1'b1, 1'b0);
        rst = 1'b1;
        tick(); check_st("abort_rst", 4'b1000, 1'b0, 1'b0);
        rst = 1'b0;
        tick(); check_st("abort_post", 4'b1000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
